// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the pushbutton conditioner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_pkg;

    // Per-channel hold-to-repeat states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } repeat_state_t;

    // Defaults sized for a 100 MHz system clock
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 10 ms
    localparam int DEF_REPEAT_DELAY    = 50000000;  // 500 ms before first repeat
    localparam int DEF_REPEAT_RATE     = 10000000;  // 100 ms between repeats
    localparam int DEF_CNT_W           = 26;

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop sync, debounce, press/release pulses, optional repeat (BTN_AUTO_REPEAT_EN).
// Latency: raw edge in cycle 0 shows on level_o and the press/release pulse in cycle DEBOUNCE_CYCLES+2.
// Backpressure: none; pulses are one cycle wide and are not held for a consumer.
module btn_chan
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
`ifdef BTN_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
`endif
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             accept;
    logic             press_acc;
    logic             rel_acc;
    logic             press_q;
    logic             release_q;

    // Debounce: count cycles the synced input disagrees with the stable level
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        accept  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
            accept  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign press_acc = accept & sync2_q;
    assign rel_acc   = accept & ~sync2_q;

    // Synchroniser, debounce state and edge pulses; pulses coincide with the level change
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_acc;
            release_q <= rel_acc;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

    repeat_state_t    state_q;
    logic [CNT_W-1:0] rcnt_q;
    logic             rep_q;

    // Hold-to-repeat FSM; an accepted release always wins over a due repeat pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            rep_q   <= 1'b0;
        end else begin
            rep_q <= 1'b0;
            if (rel_acc) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (press_acc) begin
                            state_q <= HOLD;
                            rcnt_q  <= '0;
                        end
                    end
                    HOLD: begin
                        if (rcnt_q == RD_LAST) begin
                            rep_q   <= 1'b1;
                            rcnt_q  <= '0;
                            state_q <= REPEAT;
                        end else begin
                            rcnt_q <= rcnt_q + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rcnt_q == RR_LAST) begin
                            rep_q  <= 1'b1;
                            rcnt_q <= '0;
                        end else begin
                            rcnt_q <= rcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        rcnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    // Initial press only fires from IDLE, so the two pulse sources never overlap
    assign press_o = press_q | rep_q;
`else
    assign press_o = press_q;
`endif

    assign level_o   = level_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// NUM_BTNS independent button conditioners plus an any-press OR; repeat pulses need BTN_AUTO_REPEAT_EN.
// Latency: DEBOUNCE_CYCLES+2 cycles from a clean raw edge to level and pulse; any_press is same-cycle.
// Backpressure: none; all pulse outputs are single-cycle strobes.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTNS        = 3,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                Clk100M,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic                any_press
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - longint'(1);

    // Counters must be able to reach every programmed terminal count
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > CNT_MAX ||
        REPEAT_DELAY < 1 || REPEAT_DELAY > CNT_MAX ||
        REPEAT_RATE < 1 || REPEAT_RATE > CNT_MAX) begin : g_bad_cfg
        $error("btn_conditioner: timing parameter out of range for CNT_W");
    end

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
        btn_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
`ifdef BTN_AUTO_REPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
`endif
        ) u_chan (
            .clk_i     (Clk100M),
            .rst_ni    (rst_n),
            .raw_i     (btn_raw[gi]),
            .level_o   (btn_level[gi]),
            .press_o   (btn_press[gi]),
            .release_o (btn_release[gi])
        );
    end

    assign any_press = |btn_press;

endmodule
